// File: rtl/aplic_msi_scheduler.sv
// MSI delivery sequencer for the APLIC domain: round-robin selection of pending+enabled
// sources, one MSI write per source over a valid/ready channel, then the pending clear.
module aplic_msi_scheduler #(
    parameter int NR_SRC  = 32,
    parameter int HART_W  = 4,
    parameter int EIID_W  = 11,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                       i_clk,
    input  logic                       ni_rst,
    input  logic                       i_domain_ie,
    input  logic [NR_SRC-1:0]          i_pending,
    input  logic [NR_SRC-1:0]          i_enabled,
    input  logic [NR_SRC*HART_W-1:0]   i_target_hart,
    input  logic [NR_SRC*EIID_W-1:0]   i_target_eiid,
    input  logic [ADDR_W-1:0]          i_msi_base,
    output logic                       o_msi_valid,
    input  logic                       i_msi_ready,
    output logic [ADDR_W-1:0]          o_msi_addr,
    output logic [31:0]                o_msi_data,
    input  logic                       i_msi_bvalid,
    input  logic                       i_msi_berr,
    output logic [NR_SRC-1:0]          o_clr_pending,
    output logic                       o_busy,
    output logic                       o_err
);

    localparam int IDX_W = $clog2(NR_SRC);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DROP      = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [EIID_W-1:0]   eiid_q, eiid_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    logic [NR_SRC-1:0]   cand;
    logic                hi_found, lo_found;
    logic [IDX_W-1:0]    hi_idx, lo_idx, sel_idx;
    logic [HART_W-1:0]   sel_hart;
    logic [EIID_W-1:0]   sel_eiid;
    logic [IDX_W-1:0]    rr_next;
    logic [NR_SRC-1:0]   idx_onehot;

    // Round-robin pick: lowest candidate at or above the pointer, else lowest overall.
    always_comb begin
        cand     = i_pending & i_enabled & {NR_SRC{i_domain_ie}};
        cand[0]  = 1'b0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NR_SRC - 1; i >= 1; i--) begin
            if (cand[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
                if (i >= int'(rr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        sel_idx  = hi_found ? hi_idx : lo_idx;
        sel_hart = i_target_hart[int'(sel_idx)*HART_W +: HART_W];
        sel_eiid = i_target_eiid[int'(sel_idx)*EIID_W +: EIID_W];
    end

    assign rr_next    = (idx_q == IDX_W'(NR_SRC - 1)) ? IDX_W'(1) : idx_q + 1'b1;
    assign idx_onehot = {{(NR_SRC-1){1'b0}}, 1'b1} << idx_q;

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        eiid_d        = eiid_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        o_msi_valid   = 1'b0;
        o_clr_pending = '0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (lo_found) begin
                    idx_d   = sel_idx;
                    eiid_d  = sel_eiid;
                    addr_d  = i_msi_base + (ADDR_W'(sel_hart) << 12);
                    state_d = (sel_eiid == '0) ? DROP : ISSUE;
                end
            end
            ISSUE: begin
                // Request is held until accepted regardless of source state changes.
                o_msi_valid = 1'b1;
                if (i_msi_ready) begin
                    o_clr_pending = idx_onehot;
                    rr_d          = rr_next;
                    cnt_d         = '0;
                    state_d       = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (i_msi_bvalid) begin
                    if (i_msi_berr) begin
                        err_d = 1'b1;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DROP: begin
                o_clr_pending = idx_onehot;
                rr_d          = rr_next;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            state_q <= IDLE;
            rr_q    <= IDX_W'(1);
            idx_q   <= '0;
            addr_q  <= '0;
            eiid_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            eiid_q  <= eiid_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign o_msi_addr = addr_q;
    assign o_msi_data = {{(32-EIID_W){1'b0}}, eiid_q};
    assign o_busy     = (state_q != IDLE);
    assign o_err      = err_q;

endmodule
